rf_write_arbiter: RTL and testbench

//   Shares the single write port of the 4 x 16-bit register file among NREQ requesters.

---
 rtl/rf_pkg.sv | 15 +
 rtl/rf_write_arbiter_if.sv | 33 +++
 rtl/rf_write_arbiter_rr_pick.sv | 27 ++
 rtl/rf_write_arbiter.sv | 168 ++++++++++++++++
 tb/tb_rf_write_arbiter.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/rf_pkg.sv
// Shared definitions for the register-file write path: geometry of the
// 4 x 16-bit register file and the arbiter state encoding.
package rf_pkg;

  localparam int RF_DW   = 16;
  localparam int RF_AW   = 2;
  localparam int RF_NREG = 4;

  // IDLE: round-robin selection; HOLD: a locked burst owns the write port.
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

endpackage

// File: rtl/rf_write_arbiter_if.sv
// Requester-side bus of the register-file write arbiter, plus the
// registered write port that drives the register file.
interface rf_write_arbiter_if
  import rf_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int DW   = RF_DW,
  parameter int AW   = RF_AW
);

  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    lock;
  logic [NREQ*AW-1:0] wsel_in;
  logic [NREQ*DW-1:0] wdata_in;
  logic [NREQ-1:0]    gnt;
  logic               rf_en;
  logic [AW-1:0]      rf_wsel;
  logic [DW-1:0]      rf_d;
  logic               busy;

  // Requesters drive writes and observe grants / the register-file port.
  modport master (
    output req, lock, wsel_in, wdata_in,
    input  gnt, rf_en, rf_wsel, rf_d, busy
  );

  // The arbiter consumes requests and produces grants and the write port.
  modport slave (
    input  req, lock, wsel_in, wdata_in,
    output gnt, rf_en, rf_wsel, rf_d, busy
  );

endinterface

// File: rtl/rf_write_arbiter_rr_pick.sv
// Rotating-priority encoder: picks the first asserted request starting at
// ptr and wrapping modulo NREQ. Returns the winner both one-hot and as index.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] pick,
  output logic [PW-1:0]   idx
);

  // Scan offsets from farthest to nearest so the nearest request to ptr wins.
  always_comb begin
    pick = {NREQ{1'b0}};
    idx  = {PW{1'b0}};
    for (int k = NREQ - 1; k >= 0; k--) begin
      int  j;
      logic hit;
      j    = (int'(ptr) + k) % NREQ;
      hit  = req[j];
      pick = hit ? (NREQ'(1'b1) << j) : pick;
      idx  = hit ? PW'(j) : idx;
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the single write port of the register file among NREQ requesters.
// Grants rotate round-robin; a locking requester may keep the port for a
// burst of up to MAX_HOLD writes. The accepted write is presented to the
// register file on registered rf_en/rf_wsel/rf_d one cycle after acceptance.
module rf_write_arbiter
  import rf_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int DW       = RF_DW,
  parameter int AW       = RF_AW,
  parameter int MAX_HOLD = 4
) (
  input  logic              clk,
  input  logic              rst,
  rf_write_arbiter_if.slave bus
);

  localparam int PW = $clog2(NREQ);
  localparam int HW = $clog2(MAX_HOLD + 1);

  state_t          state;
  state_t          state_nx;
  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   rr_ptr_nx;
  logic [PW-1:0]   owner;
  logic [PW-1:0]   owner_nx;
  logic [HW-1:0]   hold_cnt;
  logic [HW-1:0]   hold_cnt_nx;

  logic [NREQ-1:0] pick;
  logic [PW-1:0]   pick_idx;
  logic [NREQ-1:0] gnt_sel;
  logic [PW-1:0]   win;
  logic            accept;

  logic            wr_en;
  logic [AW-1:0]   wr_sel;
  logic [DW-1:0]   wr_data;
  logic            hold_flag;

  // Next round-robin start position after requester i has been served.
  function automatic logic [PW-1:0] ptr_after(input logic [PW-1:0] i);
    logic [PW-1:0] nxt;
    if (i == PW'(NREQ - 1)) begin
      nxt = {PW{1'b0}};
    end else begin
      nxt = i + PW'(1'b1);
    end
    return nxt;
  endfunction

  rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_pick (
    .req  (bus.req),
    .ptr  (rr_ptr),
    .pick (pick),
    .idx  (pick_idx)
  );

  // Grant decode: round-robin pick in IDLE, owner only in HOLD, none in reset.
  always_comb begin
    gnt_sel = {NREQ{1'b0}};
    win     = owner;
    if (rst) begin
      gnt_sel = {NREQ{1'b0}};
    end else begin
      case (state)
        ST_IDLE: begin
          gnt_sel = pick;
          win     = pick_idx;
        end
        ST_HOLD: begin
          gnt_sel[owner] = bus.req[owner];
          win            = owner;
        end
        default: begin
          gnt_sel = {NREQ{1'b0}};
          win     = owner;
        end
      endcase
    end
  end

  assign accept  = |(bus.req & gnt_sel);
  assign bus.gnt = gnt_sel;

  // Next-state logic: burst entry, burst continuation and port release.
  always_comb begin
    state_nx    = state;
    rr_ptr_nx   = rr_ptr;
    owner_nx    = owner;
    hold_cnt_nx = hold_cnt;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (bus.lock[win] && (MAX_HOLD > 1)) begin
            state_nx    = ST_HOLD;
            owner_nx    = win;
            hold_cnt_nx = HW'(1'b1);
          end else begin
            rr_ptr_nx   = ptr_after(win);
          end
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_HOLD: begin
        // Stay only while the owner keeps writing, keeps locking and has budget.
        if (accept && bus.lock[owner] && ((int'(hold_cnt) + 1) < MAX_HOLD)) begin
          hold_cnt_nx = hold_cnt + HW'(1'b1);
        end else begin
          state_nx    = ST_IDLE;
          rr_ptr_nx   = ptr_after(owner);
          hold_cnt_nx = {HW{1'b0}};
        end
      end
      default: begin
        state_nx    = ST_IDLE;
        rr_ptr_nx   = {PW{1'b0}};
        owner_nx    = {PW{1'b0}};
        hold_cnt_nx = {HW{1'b0}};
      end
    endcase
  end

  // Arbitration state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      rr_ptr   <= {PW{1'b0}};
      owner    <= {PW{1'b0}};
      hold_cnt <= {HW{1'b0}};
    end else begin
      state    <= state_nx;
      rr_ptr   <= rr_ptr_nx;
      owner    <= owner_nx;
      hold_cnt <= hold_cnt_nx;
    end
  end

  // Register-file write port: capture the accepted write, hold select/data otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en     <= 1'b0;
      wr_sel    <= {AW{1'b0}};
      wr_data   <= {DW{1'b0}};
      hold_flag <= 1'b0;
    end else begin
      wr_en     <= accept;
      hold_flag <= (state_nx == ST_HOLD);
      if (accept) begin
        wr_sel  <= bus.wsel_in[int'(win) * AW +: AW];
        wr_data <= bus.wdata_in[int'(win) * DW +: DW];
      end else begin
        wr_sel  <= wr_sel;
        wr_data <= wr_data;
      end
    end
  end

  assign bus.rf_en   = wr_en;
  assign bus.rf_wsel = wr_sel;
  assign bus.rf_d    = wr_data;
  assign bus.busy    = hold_flag;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter: table of round-robin vectors plus
// hand sequences for bursts, early release, reset mid-burst and write ordering
// into an attached 4 x 16-bit register file.
module tb_rf_write_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  localparam logic [7:0] WS_ID = 8'b11_10_01_00;  // requester i targets register i

  typedef struct packed {
    logic [1:0]  ws;
    logic [15:0] d;
  } wr_t;

  typedef struct {
    logic [3:0] req;
    logic [3:0] lock;
    logic [3:0] gnt;
    logic       busy;
  } vec_t;

  wr_t        sb[$];
  vec_t       tbl[9];
  logic [15:0] rmem[4];

  rf_write_arbiter_if #(.NREQ(4), .DW(16), .AW(2)) bus ();

  rf_write_arbiter #(
    .NREQ     (4),
    .DW       (16),
    .AW       (2),
    .MAX_HOLD (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Register file attached to the arbiter's write port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) rmem[i] <= 16'h0000;
    end else if (bus.rf_en) begin
      rmem[bus.rf_wsel] <= bus.rf_d;
    end
  end

  // Grant sanity on every cycle: at most one grant, never without a request.
  always @(negedge clk) begin
    n_tests++;
    if (!$onehot0(bus.gnt) || ((bus.gnt & ~bus.req) != 4'b0000)) begin
      n_fail++;
      $display("FAIL gnt_sanity: gnt=%b req=%b at %0t", bus.gnt, bus.req, $time);
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic int oh_idx(input logic [3:0] v);
    int r;
    r = 0;
    for (int i = 0; i < 4; i++) if (v[i]) r = i;
    return r;
  endfunction

  // One cycle: drive inputs, check grant, then check the registered write port.
  task automatic step(input string name, input logic [3:0] r, input logic [3:0] l,
                      input logic [7:0] ws, input logic [63:0] wd,
                      input logic [3:0] eg, input logic eb);
    wr_t  e;
    logic exp_en;
    int   w;
    bus.req      = r;
    bus.lock     = l;
    bus.wsel_in  = ws;
    bus.wdata_in = wd;
    #2;
    chk({name, ".gnt"}, 64'(bus.gnt), 64'(eg));
    exp_en = |(r & eg);
    if (exp_en) begin
      w    = oh_idx(eg);
      e.ws = ws[w*2 +: 2];
      e.d  = wd[w*16 +: 16];
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    chk({name, ".rf_en"}, 64'(bus.rf_en), 64'(exp_en));
    if (exp_en) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL %s.scoreboard: got empty queue, expected one entry", name);
      end else begin
        e = sb.pop_front();
        chk({name, ".rf_wsel"}, 64'(bus.rf_wsel), 64'(e.ws));
        chk({name, ".rf_d"}, 64'(bus.rf_d), 64'(e.d));
      end
    end
    chk({name, ".busy"}, 64'(bus.busy), 64'(eb));
  endtask

  initial begin
    logic [63:0] wd;

    // Round-robin sweep followed by a single win that leaves rr_ptr at 1.
    for (int k = 0; k < 8; k++) begin
      tbl[k].req  = 4'b1111;
      tbl[k].lock = 4'b0000;
      tbl[k].gnt  = 4'b0001 << (k % 4);
      tbl[k].busy = 1'b0;
    end
    tbl[8].req  = 4'b0001;
    tbl[8].lock = 4'b0000;
    tbl[8].gnt  = 4'b0001;
    tbl[8].busy = 1'b0;

    // Reset with traffic asserted: port quiet, no grant.
    rst          = 1'b1;
    bus.req      = 4'b1111;
    bus.lock     = 4'b0000;
    bus.wsel_in  = WS_ID;
    bus.wdata_in = 64'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.gnt", 64'(bus.gnt), 64'h0);
    chk("reset.rf_en", 64'(bus.rf_en), 64'h0);
    chk("reset.rf_wsel", 64'(bus.rf_wsel), 64'h0);
    chk("reset.rf_d", 64'(bus.rf_d), 64'h0);
    chk("reset.busy", 64'(bus.busy), 64'h0);
    rst     = 1'b0;
    bus.req = 4'b0000;

    for (int k = 0; k < 9; k++) begin
      for (int i = 0; i < 4; i++) wd[i*16 +: 16] = 16'(4096 * i + 16 * k + 5);
      step($sformatf("rr%0d", k), tbl[k].req, tbl[k].lock, WS_ID, wd, tbl[k].gnt, tbl[k].busy);
    end

    // Locked burst by requester 1 is capped at four writes; then 3 is next.
    for (int k = 1; k <= 5; k++) begin
      wd = {16'h3E3E, 16'h2E2E, 16'hA000 + 16'(k), 16'h0E0E};
      if (k <= 4)
        step($sformatf("burst%0d", k), 4'b1011, 4'b0010, WS_ID, wd, 4'b0010, (k < 4));
      else
        step("burst_after", 4'b1011, 4'b0010, WS_ID, wd, 4'b1000, 1'b0);
    end

    // Requester 2 locks, drops req after two writes: one empty cycle, then 3.
    wd = {16'h4D03, 16'h4D02, 16'h4D01, 16'h4D00};
    step("drop1", 4'b0100, 4'b0100, WS_ID, wd, 4'b0100, 1'b1);
    step("drop2", 4'b1101, 4'b0100, WS_ID, wd, 4'b0100, 1'b1);
    step("drop_gap", 4'b1001, 4'b0000, WS_ID, wd, 4'b0000, 1'b0);
    step("drop_next", 4'b1101, 4'b0000, WS_ID, wd, 4'b1000, 1'b0);

    // Reset in the middle of a burst with a write pending on the port.
    wd = {16'h5503, 16'h5502, 16'h5501, 16'h5500};
    step("midrst_burst", 4'b0001, 4'b0001, WS_ID, wd, 4'b0001, 1'b1);
    bus.req = 4'b1111;
    #1 rst = 1'b1;
    #1;
    chk("midrst.gnt", 64'(bus.gnt), 64'h0);
    chk("midrst.rf_en", 64'(bus.rf_en), 64'h0);
    chk("midrst.rf_d", 64'(bus.rf_d), 64'h0);
    chk("midrst.busy", 64'(bus.busy), 64'h0);
    @(posedge clk);
    #1;
    rst      = 1'b0;
    bus.req  = 4'b0000;
    bus.lock = 4'b0000;
    step("postrst_req2", 4'b0100, 4'b0000, WS_ID, wd, 4'b0100, 1'b0);
    step("postrst_all", 4'b1111, 4'b0000, WS_ID, wd, 4'b1000, 1'b0);

    // Back-to-back writes to r1 land in grant order.
    wd = {16'hBEEF, 16'h0000, 16'h0000, 16'h1234};
    step("order_r0", 4'b1001, 4'b0000, 8'b01_00_00_01, wd, 4'b0001, 1'b0);
    chk("order.r1_before", 64'(rmem[1]), 64'h0);
    step("order_r3", 4'b1000, 4'b0000, 8'b01_00_00_01, wd, 4'b1000, 1'b0);
    chk("order.r1_first", 64'(rmem[1]), 64'h1234);
    step("order_idle1", 4'b0000, 4'b0000, 8'b01_00_00_01, wd, 4'b0000, 1'b0);
    chk("order.r1_final", 64'(rmem[1]), 64'hBEEF);
    step("order_idle2", 4'b0000, 4'b0000, 8'b01_00_00_01, wd, 4'b0000, 1'b0);
    chk("order.r1_stable", 64'(rmem[1]), 64'hBEEF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1);
  end

endmodule
